stopwatch_core: RTL

Parametrised stopwatch engine: start/stop/clear control FSM with an integrated prescaled up/down counter, lap capture and countdown terminal detection. Sits between debounced button pulses and the display/BCD path. Generalises the existing run/pause control block by adding count width, tick prescaling, countdown mode, lap registers and a terminal state.

---
 rtl/stopwatch_pkg.sv | 12 +
 rtl/stopwatch_tick_prescaler.sv | 32 +++
 rtl/stopwatch_core.sv | 134 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: state encodings reused by the core and by
// downstream display/alarm blocks.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/stopwatch_tick_prescaler.sv
// Count-tick generator: one tick every PRESCALE enabled cycles. The phase
// holds while disabled so a resumed run continues where it paused.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_pass
      logic unused_ok;
      assign unused_ok = ^{clk, rst, sync_clr};
      assign tick      = en;
    end else begin : g_div
      localparam int PW = $clog2(PRESCALE);
      logic [PW-1:0] phase;

      assign tick = en && (phase == PW'(PRESCALE - 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst)           phase <= '0;
        else if (sync_clr) phase <= '0;
        else if (en)       phase <= tick ? '0 : phase + PW'(1);
      end
    end
  endgenerate

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch engine: run/pause/done control with a prescaled up/down counter,
// lap capture and one-cycle wrap/done event pulses.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int          CNT_W     = 16,
  parameter int unsigned MAX_COUNT = 2**CNT_W - 1,
  parameter int          PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             lap,
  input  logic             mode_down,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] lap_value,
  output logic             lap_valid,
  output logic             wrap,
  output logic             done,
  output logic             count_en,
  output logic [1:0]       state_out
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  state_t           state, state_d;
  logic [CNT_W-1:0] count_d, lap_d;
  logic             mode, mode_d;
  logic             lap_valid_d, wrap_d, done_d;
  logic             tick, go, go_down;

  // Phase is zeroed whenever not in RUN/PAUSE, so every (re)load starts a full period.
  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (state == RUN),
    .sync_clr (clr || state == IDLE || state == DONE),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d     = state;
    count_d     = count;
    mode_d      = mode;
    lap_d       = lap_value;
    lap_valid_d = 1'b0;
    wrap_d      = 1'b0;
    done_d      = 1'b0;
    go          = 1'b0;
    go_down     = mode;
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          go      = 1'b1;
          go_down = mode_down;
          mode_d  = mode_down;
        end
        RUN: begin
          if (lap) begin
            lap_d       = count;
            lap_valid_d = 1'b1;
          end
          if (tick) begin
            if (!mode) begin
              if (count == MAX_C) begin
                count_d = '0;
                wrap_d  = 1'b1;
              end else count_d = count + CNT_W'(1);
            end else if (count == CNT_W'(1)) begin
              count_d = '0;
              state_d = DONE;
              done_d  = 1'b1;
            end else count_d = count - CNT_W'(1);
          end
          // Reaching zero on the same edge as a stop still ends the countdown.
          if (stop && state_d == RUN) state_d = PAUSE;
        end
        PAUSE: begin
          if (lap) begin
            lap_d       = count;
            lap_valid_d = 1'b1;
          end
          if (start) state_d = RUN;
        end
        DONE: if (start) go = 1'b1;
      endcase
      if (go) begin
        if (go_down) begin
          count_d = load_val;
          if (load_val == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else state_d = RUN;
        end else begin
          count_d = '0;
          state_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      mode      <= 1'b0;
      lap_value <= '0;
      lap_valid <= 1'b0;
      wrap      <= 1'b0;
      done      <= 1'b0;
    end else begin
      count     <= count_d;
      mode      <= mode_d;
      lap_value <= lap_d;
      lap_valid <= lap_valid_d;
      wrap      <= wrap_d;
      done      <= done_d;
    end
  end

  assign count_en  = (state == RUN);
  assign state_out = state;

endmodule
